life_manager: RTL
=================

# life_manager

Game-logic block that owns both players' health and drives the `life1`/`life2` values consumed by the life-bar renderer. It takes damage and heal events from the explosion and bonus logic, enforces a post-hit invulnerability window, and animates the displayed life one unit per frame toward the true value. It also decides game over and the winner.

## Interface
Parameters:
- `LIFE_MAX`, 100: starting and maximum life; must be ≤ 127.
- `DAMAGE`, 25: life removed per accepted hit.
- `HEAL`, 10: life added per bonus pickup.
- `INVULN_FRAMES`, 60: frames of invulnerability after an accepted hit; must be ≤ 255.
- `BLINK_SHIFT`, 2: bit of the invulnerability counter that drives the blink output.

Ports:
- `clk` in 1: pixel clock, the same clock as the renderer.
- `reset` in 1: asynchronous, active-high.
- `new_frame` in 1: single-cycle pulse, once per frame (start of vertical blanking).
- `restart` in 1: single-cycle pulse that starts a new round.
- `hit1`, `hit2` in 1: single-cycle damage pulses, one per player.
- `bonus1`, `bonus2` in 1: single-cycle heal pulses, one per player.
- `life1`, `life2` out 7: displayed life for each player; goes to the renderer.
- `blink1`, `blink2` out 1: sprite-hide request while the player is invulnerable.
- `invuln1`, `invuln2` out 1: high while the player's invulnerability counter is nonzero.
- `game_over` out 1: high in the OVER state.
- `winner` out 2: 00 none, 01 player 1 won, 10 player 2 won, 11 draw.

## Operation
Each player has three registers:
- `target`: true life, 7 bits.
- `shown`: the value driven on `lifeN`, 7 bits.
- `inv_cnt`: invulnerability counter, 8 bits.

Top-level FSM has two states, PLAYING and OVER.

Per-player update, in priority order each cycle:
- **restart**: `target` = `shown` = `LIFE_MAX`, `inv_cnt` = 0. Applies in either state.
- **In OVER**: hits and bonuses are ignored; only the `shown` animation continues.
- **In PLAYING, target delta**:
  - A hit is accepted only when `inv_cnt` == 0. An accepted hit contributes −`DAMAGE` and loads `inv_cnt` with `INVULN_FRAMES`.
  - A bonus is always accepted and contributes +`HEAL`.
  - Hit and bonus in the same cycle: compute `target` − `DAMAGE` + `HEAL` in 9-bit signed, then clamp to [0, `LIFE_MAX`].
  - Lone hit saturates at 0; lone bonus saturates at `LIFE_MAX`.
- **inv_cnt**: on `new_frame` with `inv_cnt` ≠ 0, decrement by 1. A hit load in the same cycle overrides the decrement.
- **shown**: on `new_frame`, step ±1 toward `target`; hold when equal.

Outputs derived from the per-player registers:
- `invulnN` = (`inv_cnt` ≠ 0).
- `blinkN` = `invulnN` AND `inv_cnt[BLINK_SHIFT]`.

FSM transitions and winner:
- PLAYING → OVER when either `target` == 0. `winner` is decided from the two targets:
  - 01 if only `target2` == 0.
  - 10 if only `target1` == 0.
  - 11 if both are 0 (e.g. the same-cycle double hit that killed both).
- OVER → PLAYING on `restart`; `winner` clears to 00.
- `restart` while in PLAYING refills both players and stays in PLAYING.

## Timing
- Reset values:
  - `life1` = `life2` = `LIFE_MAX`.
  - `inv_cnt` = 0, so `blinkN` = `invulnN` = 0.
  - `game_over` = 0, `winner` = 00, FSM in PLAYING.
- Latency from an event pulse sampled at edge N:
  - `target` and `inv_cnt` update at N.
  - `invulnN` is high from N+1.
  - `game_over` and `winner` are registered and valid one cycle after `target` reaches 0.
- `shown` changes only on `new_frame` edges. A 25-unit hit needs 25 frames to fully display; a restart is visible immediately.
- Hit and `game_over` transition in the same cycle: the hit is still applied, because the FSM has not yet left PLAYING.
- `restart` coincident with a hit or bonus: `restart` wins.
- Asynchronous reset mid-round returns every register to its reset value immediately.

## Structure
- `life_pkg` holds:
  - `LIFE_W` = 7 and `INV_W` = 8.
  - `typedef enum {PLAYING, OVER} game_state_t`.
  - Winner encoding constants `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`.
- Sub-module `life_player`: holds one player's `target`, `shown` and `inv_cnt` with the delta, saturation, invulnerability and animation logic. It is instantiated twice.
- `life_manager` holds the FSM and the winner register.

## Test plan
- **Reset, then 30 frames idle:** `life1` = `life2` = 100, `game_over` = 0, `winner` = 00 throughout.
- **Single hit:** `hit1` once → `target1` = 75 next cycle and `invuln1` = 1. `life1` reaches 75 after 25 `new_frame` pulses. A second `hit1` within 60 frames is ignored. `invuln1` drops after 60 frames.
- **Hit plus bonus:** `hit1` + `bonus1` in the same cycle at `target` 100 → 85. At `target` 5, `hit1` alone → 0, never negative. At 95, `bonus1` → 100, clamped.
- **Game over:** four accepted `hit2` pulses spaced past invulnerability → `target2` = 0; one cycle later `game_over` = 1 and `winner` = 01. A later `hit1` leaves `target1` unchanged.
- **Draw:** both players at 25, `hit1` and `hit2` in the same cycle → `winner` = 11.
- **Restart and reset:** `restart` in OVER → both lives 100 and `game_over` = 0 next cycle. Asserting `reset` mid-animation returns `life1` to 100 immediately.

Source files
------------

// File: rtl/life_pkg.sv
// Shared widths, FSM state type and winner encodings for the life manager.
package life_pkg;
    localparam int LIFE_W = 7;
    localparam int INV_W  = 8;

    typedef enum logic {PLAYING, OVER} game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
endpackage

// File: rtl/life_player.sv
// One player's true life, displayed life and invulnerability counter.
module life_player
    import life_pkg::*;
#(
    parameter int LIFE_MAX      = 100,
    parameter int DAMAGE        = 25,
    parameter int HEAL          = 10,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_frame,
    input  logic              restart,
    input  logic              playing,
    input  logic              hit,
    input  logic              bonus,
    output logic [LIFE_W-1:0] target,
    output logic [LIFE_W-1:0] shown,
    output logic              invuln,
    output logic              blink
);
    localparam logic [LIFE_W-1:0] MAX_L  = LIFE_W'(LIFE_MAX);
    localparam logic [INV_W-1:0]  INV_L  = INV_W'(INVULN_FRAMES);
    localparam logic signed [8:0] DMG_S  = 9'(DAMAGE);
    localparam logic signed [8:0] HEAL_S = 9'(HEAL);

    logic [LIFE_W-1:0] target_q, target_d;
    logic [LIFE_W-1:0] shown_q, shown_d;
    logic [INV_W-1:0]  inv_q, inv_d;
    logic              hit_ok;
    logic signed [8:0] sum;

    always_comb begin
        target_d = target_q;
        shown_d  = shown_q;
        inv_d    = inv_q;
        hit_ok   = playing && hit && (inv_q == '0);
        sum      = $signed({2'b00, target_q});

        if (new_frame) begin
            if (shown_q < target_q)      shown_d = shown_q + 7'd1;
            else if (shown_q > target_q) shown_d = shown_q - 7'd1;
        end

        if (playing) begin
            if (hit_ok) sum = sum - DMG_S;
            if (bonus)  sum = sum + HEAL_S;
            if (sum < 0)                            target_d = '0;
            else if (sum > $signed({2'b00, MAX_L})) target_d = MAX_L;
            else                                    target_d = sum[LIFE_W-1:0];

            // A hit reload takes precedence over the per-frame countdown.
            if (hit_ok)                         inv_d = INV_L;
            else if (new_frame && inv_q != '0)  inv_d = inv_q - 8'd1;
        end

        if (restart) begin
            target_d = MAX_L;
            shown_d  = MAX_L;
            inv_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= MAX_L;
            shown_q  <= MAX_L;
            inv_q    <= '0;
        end else begin
            target_q <= target_d;
            shown_q  <= shown_d;
            inv_q    <= inv_d;
        end
    end

    assign target = target_q;
    assign shown  = shown_q;
    assign invuln = (inv_q != '0);
    assign blink  = invuln && inv_q[BLINK_SHIFT];
endmodule

// File: rtl/life_manager.sv
// Two-player health manager: per-player life, round FSM and winner decision.
module life_manager
    import life_pkg::*;
#(
    parameter int LIFE_MAX      = 100,
    parameter int DAMAGE        = 25,
    parameter int HEAL          = 10,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_frame,
    input  logic              restart,
    input  logic              hit1,
    input  logic              hit2,
    input  logic              bonus1,
    input  logic              bonus2,
    output logic [LIFE_W-1:0] life1,
    output logic [LIFE_W-1:0] life2,
    output logic              blink1,
    output logic              blink2,
    output logic              invuln1,
    output logic              invuln2,
    output logic              game_over,
    output logic [1:0]        winner
);
    game_state_t       state_q, state_d;
    logic [1:0]        winner_q, winner_d;
    logic              game_over_q;
    logic [LIFE_W-1:0] target1, target2;
    logic              playing;

    assign playing = (state_q == PLAYING);

    life_player #(
        .LIFE_MAX(LIFE_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL),
        .INVULN_FRAMES(INVULN_FRAMES), .BLINK_SHIFT(BLINK_SHIFT)
    ) u_p1 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .restart(restart),
        .playing(playing), .hit(hit1), .bonus(bonus1),
        .target(target1), .shown(life1), .invuln(invuln1), .blink(blink1)
    );

    life_player #(
        .LIFE_MAX(LIFE_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL),
        .INVULN_FRAMES(INVULN_FRAMES), .BLINK_SHIFT(BLINK_SHIFT)
    ) u_p2 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .restart(restart),
        .playing(playing), .hit(hit2), .bonus(bonus2),
        .target(target2), .shown(life2), .invuln(invuln2), .blink(blink2)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (restart) begin
            state_d  = PLAYING;
            winner_d = WIN_NONE;
        end else if (state_q == PLAYING && (target1 == '0 || target2 == '0)) begin
            state_d = OVER;
            if (target1 == '0 && target2 == '0) winner_d = WIN_DRAW;
            else if (target2 == '0)             winner_d = WIN_P1;
            else                                winner_d = WIN_P2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAYING;
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            game_over_q <= (state_d == OVER);
        end
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;
endmodule
